// File: rtl/fire_sched_pkg.sv
// Shared constants and helpers for the fire scheduler: policy codes, LFSR taps
// and the width rule for fire indices (one extra code for "none").
package fire_sched_pkg;

    localparam int unsigned POL_RR   = 0;
    localparam int unsigned POL_LFSR = 1;

    // Galois feedback taps for the 16-bit maximal-length LFSR
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int unsigned fire_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rot_pick.sv
// Rotating-priority picker: lowest set request at or above start, wrapping at N.
// Returns N when no request is set.
module rot_pick
    import fire_sched_pkg::*;
#(
    parameter int unsigned N = 5,
    localparam int unsigned IW = fire_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] mask;
    logic [2*N-1:0] hit;

    // Unrolled copy of req covers the wrap: window [start, start+N) holds every index once
    always_comb begin
        dbl  = {req, req};
        mask = '0;
        for (int k = 0; k < 2 * N; k++) begin
            mask[k] = (k >= int'(start)) && (k < int'(start) + int'(N));
        end
        hit = dbl & mask;
        idx = IW'(N);
        for (int k = 2 * N - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx = (k >= int'(N)) ? IW'(k - int'(N)) : IW'(k);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/fire_scheduler.sv
// Environment-side fire selector: each cycle picks one enabled transition (input
// toggle or excited stateful gate) and drives the circuit's primary inputs.
module fire_scheduler
    import fire_sched_pkg::*;
#(
    parameter int unsigned     N_IN    = 2,
    parameter int unsigned     N_ST    = 3,
    parameter logic [N_IN-1:0] INIT_IN = '0,
    parameter int unsigned     POLICY  = POL_RR,
    parameter logic [15:0]     SEED    = 16'hACE1,
    localparam int unsigned    N_TR    = N_IN + N_ST,
    localparam int unsigned    FW      = fire_width(N_TR)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [N_IN-1:0] in_can_rise,
    input  logic [N_IN-1:0] in_can_fall,
    input  logic [N_ST-1:0] st_out,
    input  logic [N_ST-1:0] st_precap,
    output logic [FW-1:0]   fire,
    output logic [N_IN-1:0] in_val,
    output logic            deadlock,
    output logic            deadlock_seen,
    output logic [15:0]     fired_cnt
);

    logic [N_TR-1:0] enabled;
    logic [FW-1:0]   pick;
    logic            any;
    logic            fire_ok;

    logic [FW-1:0]   ptr_q, ptr_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [N_IN-1:0] in_val_q, in_val_d;
    logic            seen_q;
    logic [15:0]     cnt_q;

    // An input is enabled in the direction opposite to its current level
    always_comb begin
        enabled = '0;
        for (int i = 0; i < N_IN; i++) begin
            enabled[i] = in_val_q[i] ? in_can_fall[i] : in_can_rise[i];
        end
        for (int j = 0; j < N_ST; j++) begin
            enabled[N_IN + j] = st_out[j] ^ st_precap[j];
        end
    end

    rot_pick #(
        .N (N_TR)
    ) u_pick (
        .req   (enabled),
        .start (ptr_q),
        .idx   (pick),
        .any   (any)
    );

    assign fire_ok  = en & any & ~reset;
    assign fire     = fire_ok ? pick : FW'(N_TR);
    assign deadlock = en & ~any & ~reset;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

        if (POLICY == POL_LFSR) begin
            ptr_d = FW'(lfsr_q % 16'(N_TR));
        end else begin
            ptr_d = (pick == FW'(N_TR - 1)) ? '0 : pick + FW'(1);
        end

        in_val_d = in_val_q;
        for (int i = 0; i < N_IN; i++) begin
            if (pick == FW'(i)) begin
                in_val_d[i] = ~in_val_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q    <= '0;
            lfsr_q   <= SEED;
            in_val_q <= INIT_IN;
            seen_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (en) begin
                lfsr_q <= lfsr_d;
            end
            if (fire_ok) begin
                in_val_q <= in_val_d;
                ptr_q    <= ptr_d;
                if (cnt_q != 16'hFFFF) begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end
            if (deadlock) begin
                seen_q <= 1'b1;
            end
        end
    end

    assign in_val        = in_val_q;
    assign deadlock_seen = seen_q;
    assign fired_cnt     = cnt_q;

endmodule
